fp_alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `fp_alu` instance among `NUM_REQ` requesters. It accepts one request at a time and latches that request's operands and opcode. It then drives the ALU start/ready handshake, holds the ALU inputs stable for the whole operation and returns the result to the owning requester. It sits between the requester ports and the single ALU, and adds opcode screening and a watchdog timeout.

---
 rtl/fp_alu_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_fp_alu_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_alu_arbiter.sv
// Round-robin arbiter that time-shares one fp_alu among NUM_REQ requesters.
// Latches the winner's operands, runs the ALU start/ready handshake under a watchdog and returns the result.
module fp_alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    input  logic [3*NUM_REQ-1:0]  req_op,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [31:0]           rsp_result,
    output logic                  rsp_invalid,
    output logic                  rsp_timeout,
    output logic [ID_W-1:0]       grant_id,
    output logic                  busy,
    output logic                  alu_start,
    output logic [31:0]           alu_operand_a,
    output logic [31:0]           alu_operand_b,
    output logic [2:0]            alu_opcode,
    input  logic [31:0]           alu_result,
    input  logic                  alu_invalid,
    input  logic                  alu_ready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_RESPOND
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_result_q, rsp_result_d;
    logic                 rsp_invalid_q, rsp_invalid_d;
    logic                 rsp_timeout_q, rsp_timeout_d;
    logic [ID_W-1:0]      grant_q, grant_d;
    logic [ID_W-1:0]      last_grant_q, last_grant_d;
    logic                 busy_q, busy_d;
    logic                 alu_start_q, alu_start_d;
    logic [31:0]          alu_a_q, alu_a_d;
    logic [31:0]          alu_b_q, alu_b_d;
    logic [2:0]           alu_op_q, alu_op_d;
    logic [CNT_W-1:0]     wd_cnt_q, wd_cnt_d;

    logic [ID_W:0]        pick;
    logic                 pick_found;
    logic [ID_W-1:0]      pick_id;
    logic [2:0]           pick_op;

    // Returns {found, index}. Scanning from the farthest slot back toward
    // last+1 lets the nearest valid requester overwrite the others.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    last);
        logic [ID_W:0]   res;
        logic [ID_W-1:0] idx;
        res = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(last) + k) % NUM_REQ);
            if (valid[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

    assign pick       = rr_pick(req_valid, last_grant_q);
    assign pick_found = pick[ID_W];
    assign pick_id    = pick[ID_W-1:0];
    assign pick_op    = req_op[3*pick_id +: 3];

    // NOTE: every _d starts as its _q (or its idle value) before the case, so no branch can leave a latch behind.
    always_comb begin
        state_d       = state_q;
        req_ready_d   = '0;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_invalid_d = rsp_invalid_q;
        rsp_timeout_d = rsp_timeout_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        alu_start_d   = alu_start_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        wd_cnt_d      = wd_cnt_q;

        case (state_q)
            S_IDLE: begin
                // alu_ready also gates the grant so an aborted operation can drain first.
                if (pick_found && alu_ready) begin
                    grant_d     = pick_id;
                    req_ready_d = onehot(pick_id);
                    alu_a_d     = req_a[32*pick_id +: 32];
                    alu_b_d     = req_b[32*pick_id +: 32];
                    alu_op_d    = pick_op;
                    if (pick_op[2]) begin
                        rsp_result_d  = '0;
                        rsp_invalid_d = 1'b1;
                        rsp_timeout_d = 1'b0;
                        state_d       = S_RESPOND;
                    end else begin
                        alu_start_d = 1'b1;
                        wd_cnt_d    = '0;
                        state_d     = S_ISSUE;
                    end
                end
            end

            S_ISSUE, S_BUSY: begin
                wd_cnt_d = wd_cnt_q + 1'b1;
                if (wd_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    alu_start_d   = 1'b0;
                    rsp_result_d  = '0;
                    rsp_invalid_d = 1'b0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = onehot(grant_q);
                    state_d       = S_RESPOND;
                end else if (state_q == S_ISSUE) begin
                    if (!alu_ready) begin
                        alu_start_d = 1'b0;
                        state_d     = S_BUSY;
                    end
                end else if (alu_ready) begin
                    rsp_result_d  = alu_result;
                    rsp_invalid_d = alu_invalid;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = onehot(grant_q);
                    state_d       = S_RESPOND;
                end
            end

            S_RESPOND: begin
                // An illegal opcode arrives here with rsp_valid still low; raise it
                // first so a permanently high rsp_ready cannot skip the response.
                if (rsp_valid_q == '0) begin
                    rsp_valid_d = onehot(grant_q);
                end else if (rsp_ready[grant_q]) begin
                    rsp_valid_d  = '0;
                    last_grant_d = grant_q;
                    state_d      = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: all state updates use <= so every flop samples the same pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            req_ready_q   <= '0;
            rsp_valid_q   <= '0;
            rsp_result_q  <= '0;
            rsp_invalid_q <= 1'b0;
            rsp_timeout_q <= 1'b0;
            grant_q       <= '0;
            last_grant_q  <= ID_W'(NUM_REQ - 1);
            busy_q        <= 1'b0;
            alu_start_q   <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            wd_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_invalid_q <= rsp_invalid_d;
            rsp_timeout_q <= rsp_timeout_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            busy_q        <= busy_d;
            alu_start_q   <= alu_start_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            wd_cnt_q      <= wd_cnt_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_invalid   = rsp_invalid_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign grant_id      = grant_q;
    assign busy          = busy_q;
    assign alu_start     = alu_start_q;
    assign alu_operand_a = alu_a_q;
    assign alu_operand_b = alu_b_q;
    assign alu_opcode    = alu_op_q;

endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Bench for fp_alu_arbiter: behavioural single-precision ALU model plus a round-robin
// scoreboard that predicts grant order, latency and response fields.
module tb_fp_alu_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 64;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [3*NUM_REQ-1:0]  req_op;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic [31:0]           rsp_result;
    logic                  rsp_invalid;
    logic                  rsp_timeout;
    logic [ID_W-1:0]       grant_id;
    logic                  busy;
    logic                  alu_start;
    logic [31:0]           alu_operand_a;
    logic [31:0]           alu_operand_b;
    logic [2:0]            alu_opcode;
    logic [31:0]           alu_result = '0;
    logic                  alu_invalid = 1'b0;
    logic                  alu_ready = 1'b1;

    logic [31:0] ra [NUM_REQ];
    logic [31:0] rb [NUM_REQ];
    logic [2:0]  rop[NUM_REQ];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_served;
    int prev_acc = 0;

    logic [112:0] all_outs;
    assign all_outs = {req_ready, rsp_valid, rsp_result, rsp_invalid, rsp_timeout, grant_id,
                       busy, alu_start, alu_operand_a, alu_operand_b, alu_opcode};

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
        assign req_a[32*i +: 32] = ra[i];
        assign req_b[32*i +: 32] = rb[i];
        assign req_op[3*i +: 3]  = rop[i];
    end

    fp_alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_op       (req_op),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_invalid  (rsp_invalid),
        .rsp_timeout  (rsp_timeout),
        .grant_id     (grant_id),
        .busy         (busy),
        .alu_start    (alu_start),
        .alu_operand_a(alu_operand_a),
        .alu_operand_b(alu_operand_b),
        .alu_opcode   (alu_opcode),
        .alu_result   (alu_result),
        .alu_invalid  (alu_invalid),
        .alu_ready    (alu_ready)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- single-precision helpers (normal numbers and zero) ----------------
    function automatic real sp2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Returns {invalid, result} for the ALU operation.
    function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        real x, y, z;
        x = sp2r(a);
        y = sp2r(b);
        z = 0.0;
        case (op)
            3'd0: z = x + y;
            3'd1: z = x - y;
            3'd2: z = x * y;
            3'd3: begin
                if (y == 0.0) return {1'b1, 32'h7FC00000};
                z = x / y;
            end
            default: return {1'b1, 32'h7FC00000};
        endcase
        return {1'b0, r2sp(z)};
    endfunction

    // ---------------- ALU model: takes start when ready, done 6 cycles later ----------------
    logic        alu_hang = 1'b0;
    logic [2:0]  alu_cnt = '0;
    logic [66:0] alu_snap = '0;
    logic        alu_skip = 1'b0;

    always @(posedge clk) begin
        if (alu_ready) begin
            if (alu_start) begin
                alu_ready <= 1'b0;
                alu_cnt   <= 3'd5;
                alu_snap  <= {alu_operand_a, alu_operand_b, alu_opcode};
                alu_skip  <= 1'b0;
            end
        end else begin
            if (!reset_n) alu_skip <= 1'b1;
            if (alu_cnt != 3'd0) begin
                alu_cnt <= alu_cnt - 3'd1;
            end else if (!alu_hang) begin
                {alu_invalid, alu_result} <= alu_fn(alu_operand_a, alu_operand_b, alu_opcode);
                alu_ready <= 1'b1;
                if (!alu_skip && reset_n)
                    check("alu_in_stable", {alu_operand_a, alu_operand_b, alu_opcode}, alu_snap);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] fp_tab [8] = '{32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h40400000,
                                32'h3F000000, 32'h40800000, 32'h3F400000, 32'h40200000};

    function automatic logic [31:0] rand_fp();
        return fp_tab[$urandom_range(0, 7)];
    endfunction

    function automatic logic [2:0] rand_op();
        if ($urandom_range(0, 7) == 0) return 3'(4 + $urandom_range(0, 3));
        return 3'($urandom_range(0, 3));
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] m, input int last);
        int pick;
        pick = -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (last + k) % NUM_REQ;
            if (pick < 0 && m[idx]) pick = idx;
        end
        return pick;
    endfunction

    function automatic logic [NUM_REQ-1:0] oh(input int i);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // One full transaction as the reference predicts it: accept, response, optional back-pressure.
    // rearm: 0 drop the request after accept, 1 new operands same op, 2 new operands and op.
    task automatic serve(input int hold, input int rearm, input bit exp_to, input int exp_gap,
                         output logic [NUM_REQ-1:0] got);
        int          id, waited, acc_cyc, lat;
        logic [31:0] a, b, exp_res;
        logic [2:0]  op;
        logic [32:0] r;
        logic        exp_inv, bad;
        id  = rr_pick(req_valid, last_served);
        got = '0;
        waited = 0;
        while (req_ready == '0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("accept_seen", req_ready != '0, 1'b1);
        if (req_ready == '0) return;
        got = req_ready;
        a  = ra[id];
        b  = rb[id];
        op = rop[id];
        check("grant", req_ready, oh(id));
        check("alu_inputs", {alu_operand_a, alu_operand_b, alu_opcode}, {a, b, op});
        check("alu_start_at_accept", alu_start, !op[2]);
        if (exp_gap > 0) check("accept_gap", cyc - prev_acc, exp_gap);
        acc_cyc  = cyc;
        prev_acc = cyc;
        if (exp_to) begin
            lat = TIMEOUT; exp_res = '0; exp_inv = 1'b0;
        end else if (op[2]) begin
            lat = 1; exp_res = '0; exp_inv = 1'b1;
        end else begin
            r = alu_fn(a, b, op);
            lat = 8; exp_res = r[31:0]; exp_inv = r[32];
        end
        case (rearm)
            0: req_valid[id] = 1'b0;
            1: begin ra[id] = rand_fp(); rb[id] = rand_fp(); end
            default: begin ra[id] = rand_fp(); rb[id] = rand_fp(); rop[id] = rand_op(); end
        endcase
        if (hold > 0) rsp_ready = '0;
        waited = 0;
        while (rsp_valid == '0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("rsp_seen", rsp_valid != '0, 1'b1);
        check("rsp_latency", cyc - acc_cyc, lat);
        check("rsp_valid", rsp_valid, oh(id));
        check("grant_id", grant_id, id);
        check("rsp_fields", {rsp_result, rsp_invalid, rsp_timeout}, {exp_res, exp_inv, exp_to});
        if (hold > 0) begin
            bad = 1'b0;
            repeat (hold) begin
                @(negedge clk);
                if (rsp_valid !== oh(id) || req_ready !== '0) bad = 1'b1;
            end
            check("backpressure_hold", bad, 1'b0);
            rsp_ready = '1;
            @(negedge clk);
            check("rsp_drop", rsp_valid, '0);
        end
        last_served = id;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [NUM_REQ-1:0] got;
        logic               bad;
        int                 waited;

        reset_n     = 1'b0;
        req_valid   = '0;
        rsp_ready   = '1;
        last_served = NUM_REQ - 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            ra[i] = '0; rb[i] = '0; rop[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs, '0);
        reset_n = 1'b1;
        @(negedge clk);

        // Requester 1: 1.5 + 2.0
        ra[1] = 32'h3FC00000; rb[1] = 32'h40000000; rop[1] = 3'b000; req_valid[1] = 1'b1;
        serve(0, 0, 1'b0, 0, got);
        check("single_grant", got, 4'b0010);
        check("single_result", {rsp_result, rsp_invalid}, {32'h40600000, 1'b0});

        // All requesters from reset: strict rotation, 10 cycles per operation
        reset_n = 1'b0;
        @(negedge clk);
        reset_n     = 1'b1;
        last_served = NUM_REQ - 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            ra[i] = rand_fp(); rb[i] = rand_fp(); rop[i] = 3'(i);
        end
        req_valid = '1;
        for (int i = 0; i < 5; i++) begin
            serve(0, 1, 1'b0, (i > 0) ? 10 : 0, got);
            check("rotation_order", got, oh(i % NUM_REQ));
        end
        req_valid = '0;

        // Divide by zero reported invalid by the ALU
        ra[2] = 32'h3F800000; rb[2] = 32'h00000000; rop[2] = 3'b011; req_valid[2] = 1'b1;
        serve(0, 0, 1'b0, 0, got);
        check("div0_invalid", {rsp_invalid, rsp_valid}, {1'b1, 4'b0100});

        // Illegal opcode screened without starting the ALU
        ra[3] = rand_fp(); rb[3] = rand_fp(); rop[3] = 3'b101; req_valid[3] = 1'b1;
        serve(0, 0, 1'b0, 0, got);
        check("illegal_flags", {rsp_invalid, rsp_result, alu_start}, {1'b1, 32'h0, 1'b0});

        // Watchdog abort with the ALU stuck, then no grant until it recovers
        alu_hang = 1'b1;
        ra[0] = rand_fp(); rb[0] = rand_fp(); rop[0] = 3'b010; req_valid[0] = 1'b1;
        serve(0, 0, 1'b1, 0, got);
        check("timeout_flags", {rsp_timeout, rsp_result, rsp_invalid, alu_start},
              {1'b1, 32'h0, 1'b0, 1'b0});
        ra[1] = rand_fp(); rb[1] = rand_fp(); rop[1] = 3'b000; req_valid[1] = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (req_ready != '0) bad = 1'b1;
        end
        check("no_grant_while_alu_busy", bad, 1'b0);
        check("idle_after_timeout", busy, 1'b0);
        alu_hang = 1'b0;
        serve(0, 0, 1'b0, 0, got);
        check("grant_after_recovery", got, 4'b0010);

        // Back-pressure: response held, other requester waits
        ra[2] = rand_fp(); rb[2] = rand_fp(); rop[2] = 3'b010; req_valid[2] = 1'b1;
        ra[3] = rand_fp(); rb[3] = rand_fp(); rop[3] = 3'b001; req_valid[3] = 1'b1;
        serve(5, 0, 1'b0, 0, got);
        serve(0, 0, 1'b0, 0, got);
        check("after_backpressure", got, 4'b1000);

        // Reset while BUSY; ALU keeps running and gates the first grant after release
        ra[1] = rand_fp(); rb[1] = rand_fp(); rop[1] = 3'b000; req_valid[1] = 1'b1;
        waited = 0;
        while (req_ready == '0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("rst_test_accept", req_ready, 4'b0010);
        req_valid = '0;
        repeat (3) @(negedge clk);
        check("busy_before_reset", {busy, alu_start}, 2'b10);
        #2 reset_n = 1'b0;
        #1 check("reset_mid_busy", all_outs, '0);
        ra[0] = rand_fp(); rb[0] = rand_fp(); rop[0] = 3'b011;
        ra[3] = rand_fp(); rb[3] = rand_fp(); rop[3] = 3'b000;
        req_valid = 4'b1001;
        @(negedge clk);
        @(negedge clk);
        reset_n     = 1'b1;
        last_served = NUM_REQ - 1;
        bad = 1'b0;
        waited = 0;
        while (!alu_ready && waited < 50) begin
            if (req_ready != '0) bad = 1'b1;
            @(negedge clk);
            waited++;
        end
        check("no_grant_before_alu_ready", bad, 1'b0);
        serve(0, 0, 1'b0, 0, got);
        check("first_grant_after_reset", got, 4'b0001);

        // Randomised traffic
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    ra[i] = rand_fp(); rb[i] = rand_fp(); rop[i] = rand_op();
                    req_valid[i] = 1'b1;
                end
            end
            if (req_valid == '0) begin
                int j;
                j = $urandom_range(0, NUM_REQ - 1);
                ra[j] = rand_fp(); rb[j] = rand_fp(); rop[j] = rand_op();
                req_valid[j] = 1'b1;
            end
            serve(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                  $urandom_range(0, 2), 1'b0, 0, got);
        end
        req_valid = '0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
